// File: rtl/spad_pkg.sv
// -----------------------------------------------------------------------------
// spad_pkg
// Shared definitions for the scratchpad stream reader:
//   - default word / address widths
//   - reader FSM state encoding
//   - output buffer geometry (2 entries)
// -----------------------------------------------------------------------------
package spad_pkg;

  localparam int SPAD_DATA_WIDTH = 32;
  localparam int SPAD_ADDR_WIDTH = 10;

  // Output buffer: two slots are enough to cover one in-flight read plus
  // one beat parked under backpressure while still streaming 1 word/cycle.
  localparam int BUF_DEPTH = 2;
  localparam int BUF_PTR_W = 1;
  localparam int BUF_CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/spad_skid_fifo.sv
// -----------------------------------------------------------------------------
// spad_skid_fifo
// Two-entry FIFO holding returned scratchpad words together with their
// end-of-burst flag. Head data/last come straight from storage registers, so
// they stay stable while the head is not popped.
// Ports:
//   clk, rst_n          clock, async active-low reset (clears storage)
//   push_i, push_data_i, push_last_i   write one entry
//   pop_i               remove head entry
//   count_o             number of stored entries (0..2)
//   full_o, empty_o     occupancy flags
//   head_data_o, head_last_o           current head entry
// Push while full / pop while empty must not be requested by the parent.
// -----------------------------------------------------------------------------
module spad_skid_fifo
  import spad_pkg::*;
#(
  parameter int DATA_WIDTH = SPAD_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  push_last_i,
  input  logic                  pop_i,
  output logic [BUF_CNT_W-1:0]  count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic                  head_last_o
);

  logic [DATA_WIDTH-1:0] data_q [BUF_DEPTH];
  logic                  last_q [BUF_DEPTH];
  logic [BUF_PTR_W-1:0]  wr_ptr_q;
  logic [BUF_PTR_W-1:0]  rd_ptr_q;
  logic [BUF_CNT_W-1:0]  count_q;

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        data_q[wr_ptr_q] <= push_data_i;
        last_q[wr_ptr_q] <= push_last_i;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count_o     = count_q;
  assign full_o      = (count_q == 2'd2);
  assign empty_o     = (count_q == 2'd0);
  assign head_data_o = data_q[rd_ptr_q];
  assign head_last_o = last_q[rd_ptr_q];

endmodule

// File: rtl/spad_stream_reader.sv
// -----------------------------------------------------------------------------
// spad_stream_reader
// Reads a burst of `length` words starting at `base_addr` from the scratchpad
// read port (1-cycle read latency) and streams them on a valid/ready master
// interface, 1 word/cycle when m_ready stays high, lossless under backpressure.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, base_addr, length   burst request (sampled only in IDLE)
//   busy, done                 burst in progress / 1-cycle completion pulse
//   re_b, addr_b, rdata_b      scratchpad read port
//   m_valid, m_data, m_last, m_ready   output stream
// Optional (macro SPAD_RD_PERF_EN):
//   stall_cycles               saturating count of busy && m_valid && !m_ready
// -----------------------------------------------------------------------------
module spad_stream_reader
  import spad_pkg::*;
#(
  parameter int DATA_WIDTH = SPAD_DATA_WIDTH,
  parameter int ADDR_WIDTH = SPAD_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  re_b,
  output logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
`ifdef SPAD_RD_PERF_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   rem_q;            // reads still to issue
  logic                  busy_q;
  logic                  done_q;
  logic                  inflight_q;       // read issued last cycle, data on rdata_b now
  logic                  inflight_last_q;  // that read is the final word of the burst

  logic [BUF_CNT_W-1:0]  fifo_count_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  pop_s;
  logic [2:0]            occ_s;
  logic                  issue_s;
  logic                  unused_fifo_full_s;

  assign pop_s = m_valid && m_ready;
  // Full is already implied by the credit check below.
  assign unused_fifo_full_s = fifo_full_s;

  // Credit check: slots committed after this cycle's pop must leave room
  // for one more word, so returned data never finds the buffer full.
  always_comb begin
    occ_s = {1'b0, fifo_count_s} + {2'b00, inflight_q} - {2'b00, pop_s};
    if ((state_q == RUN) && (occ_s < 3'd2)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Reader FSM with address generation and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      done_q          <= 1'b0;
      inflight_q      <= issue_s;
      inflight_last_q <= issue_s && (rem_q == (ADDR_WIDTH+1)'(1));
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q <= base_addr;
            rem_q  <= length;
            if (length == '0) begin
              // Empty burst: straight to completion, nothing read or emitted.
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue_s) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);  // wraps modulo the scratchpad depth
            rem_q  <= rem_q - (ADDR_WIDTH+1)'(1);
            if (rem_q == (ADDR_WIDTH+1)'(1)) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // The last-flagged beat can only leave after every read has landed.
          if (pop_s && m_last) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  spad_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i (rdata_b),
    .push_last_i (inflight_last_q),
    .pop_i       (pop_s),
    .count_o     (fifo_count_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .head_data_o (m_data),
    .head_last_o (m_last)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign re_b    = issue_s;
  assign addr_b  = addr_q;
  assign m_valid = !fifo_empty_s;

`ifdef SPAD_RD_PERF_EN
  logic [31:0] stall_q;

  // Backpressure stall counter: restarts per burst, saturates, holds in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      stall_q <= '0;
    end else if (busy_q && m_valid && !m_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end else begin
      stall_q <= stall_q;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_spad_stream_reader.sv
module tb_spad_stream_reader;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, re_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] rdata_b = '0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready = 1'b0;
`ifdef SPAD_RD_PERF_EN
  logic [31:0]   stall_cycles;
`endif

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  // Scratchpad model: data appears one cycle after re_b.
  always @(posedge clk) if (re_b) rdata_b <= mem[addr_b];

  spad_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .re_b(re_b), .addr_b(addr_b), .rdata_b(rdata_b),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
`ifdef SPAD_RD_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},    busy, 0);
    chk({tag, "_done"},    done, 0);
    chk({tag, "_re_b"},    re_b, 0);
    chk({tag, "_addr_b"},  addr_b, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"},  m_data, 0);
    chk({tag, "_m_last"},  m_last, 0);
  endtask

  // One burst: the expected beats are the memory words base..base+len-1
  // (mod depth), the last one flagged. Mode: 0 ready=1, 1 random,
  // 2 pattern 1,0,0, 3 ready low for the first 3 valid cycles.
  task automatic run_burst(input logic [AW-1:0] b, input int len, input int mode,
                           input int exp_first, input int exp_done);
    logic [DW-1:0] exp_q[$];
    int issued = 0, popped = 0, first = -1, done_at = -1, last_pop = -1;
    int v_credit = 0, v_stable = 0, v_busy = 0, extra_rd = 0, stalls = 0, lowcnt = 0;
    int budget = 40 + 6 * len;
    logic prev_stall = 1'b0, prev_l = 1'b0, pop;
    logic [DW-1:0] prev_d = '0;
    logic [31:0] stall_at_done = '0;
    for (int k = 0; k < len; k++) exp_q.push_back(mem[(int'(b) + k) % DEPTH]);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = len[AW:0]; m_ready = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        start = 1'b0;
        base_addr = AW'($urandom);   // later changes must not matter
        length = (AW+1)'($urandom);
      end
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = 1'($urandom_range(0, 1));
        2: m_ready = ((c - 1) % 3 == 0);
        default: begin
          m_ready = !(m_valid && lowcnt < 3);
          if (m_valid && lowcnt < 3) lowcnt++;
        end
      endcase
      #1;
      pop = m_valid && m_ready;
      if (re_b) begin
        if (issued >= len) extra_rd++;
        else begin
          chk("rd_addr", addr_b, (int'(b) + issued) % DEPTH);
          if ((issued - popped) - (pop ? 1 : 0) >= 2) v_credit++;
        end
        issued++;
      end
      if (prev_stall && (!m_valid || m_data !== prev_d || m_last !== prev_l)) v_stable++;
      if (m_valid && first < 0) first = c;
      if (pop) begin
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          chk("beat_data", m_data, exp_q[0]);
          chk("beat_last", m_last, exp_q.size() == 1);
          void'(exp_q.pop_front());
        end
        popped++;
        last_pop = c;
      end
      prev_stall = m_valid && !m_ready; prev_d = m_data; prev_l = m_last;
      if (busy && m_valid && !m_ready) stalls++;
      if (done) begin
        done_at = c;
`ifdef SPAD_RD_PERF_EN
        stall_at_done = stall_cycles;
`endif
        chk("done_busy_low", busy, 0);
        break;
      end
      if (busy !== (len > 0)) v_busy++;
    end
    chk("done_seen", done_at >= 0, 1);
    chk("beat_count", popped, len);
    chk("read_count", issued, len);
    chk("extra_reads", extra_rd, 0);
    chk("credit_violations", v_credit, 0);
    chk("stall_stability", v_stable, 0);
    chk("busy_window", v_busy, 0);
    if (len > 0) chk("done_after_last", done_at, last_pop + 1);
    if (exp_done != 0) chk("done_cycle", done_at, exp_done);
    if (exp_first != 0) chk("first_valid_cycle", first, exp_first);
    @(posedge clk); #1;
    m_ready = 1'b0;
    #1;
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_re_b", re_b, 0);
    chk("idle_m_valid", m_valid, 0);
`ifdef SPAD_RD_PERF_EN
    chk("stall_cycles_at_done", stall_at_done, stalls);
    chk("stall_cycles_hold", stall_cycles, stalls);
`endif
  endtask

  typedef struct {
    logic [AW-1:0] base;
    int len;
    int mode;
    int exp_first;
    int exp_done;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int cnt;
    vecs[0] = '{10'd5,    4,    0, 3, 7};
    vecs[1] = '{10'd1022, 4,    0, 3, 7};
    vecs[2] = '{10'd0,    8,    2, 0, 0};
    vecs[3] = '{10'd7,    0,    0, 0, 1};
    vecs[4] = '{10'd1023, 1,    0, 3, 4};
    vecs[5] = '{10'd900,  2,    0, 3, 5};
    vecs[6] = '{10'd64,   4,    3, 0, 0};
    vecs[7] = '{10'd1000, 40,   1, 0, 0};
    vecs[8] = '{10'd512,  1024, 0, 3, 1027};
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) run_burst(vecs[i].base, vecs[i].len, vecs[i].mode,
                                vecs[i].exp_first, vecs[i].exp_done);

    // Reset while the third beat of a 10-word burst is on the bus.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'd200; length = 11'd10; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 30 && cnt < 3; c++) begin
      @(posedge clk); #1;
      if (m_valid && m_ready) cnt++;
    end
    chk("rst_seq_reached_beat3", cnt, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    m_ready = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("midrst_no_done", done, 0);
    end
    rst_n = 1'b1;
    run_burst(10'd300, 5, 0, 3, 8);

    for (int r = 0; r < 12; r++)
      run_burst(AW'($urandom), int'($urandom_range(0, 20)), 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
